uii2c_slave: RTL

//  I2C target (slave) that answers the team's I2C master on SCL/SDA and exposes an 8-bit register-bank port.

---
 rtl/uii2c_slave.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/uii2c_slave.sv
// I2C target with an 8-bit register-bank port: pointer/data writes with auto-increment,
// reads from the current pointer. SCL/SDA are oversampled and glitch-filtered in I_clk.
module uii2c_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'h3C,
    parameter int unsigned FILT_LEN = 3,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_iic_scl,
    inout  wire        IO_iic_sda,
    output logic [7:0] O_reg_addr,
    output logic [7:0] O_reg_wdata,
    output logic       O_reg_wr,
    output logic       O_reg_rd,
    input  logic [7:0] I_reg_rdata,
    output logic       O_iic_busy,
    output logic       O_iic_sda_dg
);

    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRackChk, StIgnore
    } state_e;

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0] sync1, sync2, filt, filt_prev;
    logic [3:0] fcnt [2];

    state_e     state;
    logic [3:0] bit_cnt;
    logic [7:0] sh;
    logic [7:0] ptr;
    logic       rw;
    logic       sda_o;
    logic       sda_pend;
    logic [7:0] hold_cnt;
    logic       fetch;
    logic       ptr_inc;

    logic       scl_f, sda_f;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            filt      <= 2'b11;
            filt_prev <= 2'b11;
            fcnt[0]   <= '0;
            fcnt[1]   <= '0;
        end else begin
            sync1     <= {IO_iic_sda, I_iic_scl};
            sync2     <= sync1;
            filt_prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_MAX) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_rise  = scl_f & ~filt_prev[0];
    assign scl_fall  = ~scl_f & filt_prev[0];
    assign start_det = scl_f & filt_prev[0] & filt_prev[1] & ~sda_f;
    assign stop_det  = scl_f & filt_prev[0] & ~filt_prev[1] & sda_f;
    assign rx_byte   = {sh[6:0], sda_f};

    assign IO_iic_sda   = sda_o ? 1'bz : 1'b0;
    assign O_iic_sda_dg = sda_f;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state       <= StIdle;
            bit_cnt     <= '0;
            sh          <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            sda_o       <= 1'b1;
            sda_pend    <= 1'b1;
            hold_cnt    <= '0;
            fetch       <= 1'b0;
            ptr_inc     <= 1'b0;
            O_reg_addr  <= '0;
            O_reg_wdata <= '0;
            O_reg_wr    <= 1'b0;
            O_reg_rd    <= 1'b0;
            O_iic_busy  <= 1'b0;
        end else begin
            O_reg_wr <= 1'b0;
            O_reg_rd <= 1'b0;
            fetch    <= 1'b0;
            ptr_inc  <= 1'b0;
            if (fetch) sh <= I_reg_rdata;
            if (fetch || ptr_inc) ptr <= ptr + 8'd1;
            // Scheduled SDA value lands HOLD_CYC cycles after the SCL fall that queued it.
            if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
                if (hold_cnt == 8'd1) sda_o <= sda_pend;
            end

            if (start_det) begin
                state    <= StAddr;
                bit_cnt  <= '0;
                sda_o    <= 1'b1;
                hold_cnt <= '0;
            end else if (stop_det) begin
                state      <= StIdle;
                sda_o      <= 1'b1;
                hold_cnt   <= '0;
                O_iic_busy <= 1'b0;
            end else begin
                unique case (state)
                    StAddr: begin
                        if (scl_rise) begin
                            sh      <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state      <= StAddrAck;
                                    rw         <= rx_byte[0];
                                    O_iic_busy <= 1'b1;
                                end else begin
                                    state      <= StIgnore;
                                    O_iic_busy <= 1'b0;
                                end
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            sda_pend <= 1'b0;
                            hold_cnt <= HOLD_LD;
                        end else if (scl_rise) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                O_reg_rd   <= 1'b1;
                                O_reg_addr <= ptr;
                                fetch      <= 1'b1;
                                state      <= StRdata;
                            end else begin
                                state <= StPtr;
                            end
                        end
                    end
                    StPtr, StWdata: begin
                        if (scl_fall) begin
                            sda_pend <= 1'b1;
                            hold_cnt <= HOLD_LD;
                        end else if (scl_rise) begin
                            sh      <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (state == StPtr) begin
                                    ptr   <= rx_byte;
                                    state <= StPtrAck;
                                end else begin
                                    O_reg_wr    <= 1'b1;
                                    O_reg_addr  <= ptr;
                                    O_reg_wdata <= rx_byte;
                                    ptr_inc     <= 1'b1;
                                    state       <= StWdataAck;
                                end
                            end
                        end
                    end
                    StPtrAck, StWdataAck: begin
                        if (scl_fall) begin
                            sda_pend <= 1'b0;
                            hold_cnt <= HOLD_LD;
                        end else if (scl_rise) begin
                            bit_cnt <= '0;
                            state   <= StWdata;
                        end
                    end
                    StRdata: begin
                        if (scl_fall) begin
                            hold_cnt <= HOLD_LD;
                            if (bit_cnt == 4'd8) begin
                                sda_pend <= 1'b1;
                                bit_cnt  <= '0;
                                state    <= StRackChk;
                            end else begin
                                sda_pend <= sh[7];
                                sh       <= {sh[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    StRackChk: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                O_reg_rd   <= 1'b1;
                                O_reg_addr <= ptr;
                                fetch      <= 1'b1;
                                bit_cnt    <= '0;
                                state      <= StRdata;
                            end else begin
                                state <= StIgnore;
                            end
                        end
                    end
                    StIdle, StIgnore: ;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
